// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between pipeline WB and a long-latency unit, with LU result FIFO and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the committing write to decode operands instead of stalling one extra cycle.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_hold,
  input  logic            lu_issue,
  input  logic [AW-1:0]   lu_issue_rd,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic [AW-1:0]   dec_rd,
  output logic            raw_stall,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  output logic [XLEN-1:0] rd1_out,
  output logic [XLEN-1:0] rd2_out,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [AW-1:0]   fifo_rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [SW-1:0]   starve_reg, starve_next;
  logic [NREG-1:0] busy_reg, busy_next, busy_eff;

  logic            empty, full, push, pop;
  logic            wb_req, starve_force, grant_fifo, grant_wb;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;
  logic            issue_nz;
  logic            we_int, commit_match, raw_stall_int;
  logic [AW-1:0]   a3_int;
  logic [XLEN-1:0] wd_int, rd1_int, rd2_int;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_CNT);
  assign head_rd   = fifo_rd_mem[rd_ptr_reg];
  assign head_data = fifo_data_mem[rd_ptr_reg];

  // Results aimed at x0 complete the handshake but never occupy a slot.
  assign push = lu_valid & !full & (lu_rd != '0);

  assign wb_req       = wb_we & (wb_rd != '0);
  assign starve_force = (starve_reg == STARVE_LIM) & !empty;
  assign grant_fifo   = starve_force | (!wb_req & !empty);
  assign grant_wb     = wb_req & !starve_force;
  assign pop          = grant_fifo;

  assign we_int = grant_fifo | grant_wb;
  assign a3_int = grant_fifo ? head_rd   : (grant_wb ? wb_rd   : '0);
  assign wd_int = grant_fifo ? head_data : (grant_wb ? wb_data : '0);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    starve_next = starve_reg;
    if (empty || pop)
      starve_next = '0;
    else if (starve_reg != STARVE_LIM)
      starve_next = starve_reg + 1'b1;
  end

  assign issue_nz = lu_issue & (lu_issue_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      logic set_bit, clr_bit;
      assign set_bit = issue_nz & (lu_issue_rd == AW'(gi));
      assign clr_bit = pop & (head_rd == AW'(gi));
      // A new issue to the register that is committing keeps it busy.
      assign busy_next[gi] = set_bit | (busy_reg[gi] & !clr_bit);
`ifdef REGFILE_BYPASS_EN
      assign busy_eff[gi] = busy_reg[gi] & !clr_bit;
`else
      assign busy_eff[gi] = busy_reg[gi];
`endif
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  assign commit_match = 1'b0;
  assign rd1_int = (we_int && (a3_int == dec_rs1) && (dec_rs1 != '0)) ? wd_int : rd1_in;
  assign rd2_int = (we_int && (a3_int == dec_rs2) && (dec_rs2 != '0)) ? wd_int : rd2_in;
`else
  // Without forwarding, any source written this cycle is only readable next cycle.
  assign commit_match = we_int & (a3_int != '0) & ((a3_int == dec_rs1) | (a3_int == dec_rs2));
  assign rd1_int = rd1_in;
  assign rd2_int = rd2_in;
`endif

  assign raw_stall_int = busy_eff[dec_rs1] | busy_eff[dec_rs2] | busy_eff[dec_rd] | commit_match;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= lu_rd;
      fifo_data_mem[wr_ptr_reg] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      busy_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg  <= count_next;
      starve_reg <= starve_next;
      busy_reg   <= busy_next;
    end
  end

  // All outputs are held at zero while reset is asserted.
  assign wb_hold   = rst_n & starve_force;
  assign lu_ready  = rst_n & !full;
  assign raw_stall = rst_n & raw_stall_int;
  assign rf_we     = rst_n & we_int;
  assign rf_a3     = rst_n ? a3_int  : '0;
  assign rf_wd     = rst_n ? wd_int  : '0;
  assign rd1_out   = rst_n ? rd1_int : '0;
  assign rd2_out   = rst_n ? rd2_int : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle vector table plus a queue of expected LU commits.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] RD1_IN = 32'h1111_1111;
  localparam logic [31:0] RD2_IN = 32'h2222_2222;

  logic        clk, rst_n;
  logic        wb_we, wb_hold, lu_issue, lu_valid, lu_ready, raw_stall, rf_we;
  logic [4:0]  wb_rd, lu_issue_rd, lu_rd, dec_rs1, dec_rs2, dec_rd, rf_a3;
  logic [31:0] wb_data, lu_data, rd1_in, rd2_in, rd1_out, rd2_out, rf_wd;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .raw_stall(raw_stall),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        luv;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic [4:0]  rs1, rs2, rd;
    logic        hold, ready, stall;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[$];
  ent_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic wbw, input logic [4:0] wbr,
                              input logic [31:0] wbd, input logic iss, input logic [4:0] issr,
                              input logic luv, input logic [4:0] lur, input logic [31:0] lud,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic hold, input logic ready, input logic stall);
    vec_t v;
    v.name = name; v.wb_we = wbw; v.wb_rd = wbr; v.wb_data = wbd;
    v.iss = iss; v.iss_rd = issr; v.luv = luv; v.lu_rd = lur; v.lu_data = lud;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.hold = hold; v.ready = ready; v.stall = stall;
    return v;
  endfunction

  task automatic run_cycle(input vec_t v);
    logic        ewe;
    logic [4:0]  ea3;
    logic [31:0] ewd, e1, e2;
    ent_t        e, ne;
    @(negedge clk);
    wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_data;
    lu_issue = v.iss; lu_issue_rd = v.iss_rd;
    lu_valid = v.luv; lu_rd = v.lu_rd; lu_data = v.lu_data;
    dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.rd;
    #1;
    check({v.name, ".wb_hold"},   {31'd0, wb_hold},   {31'd0, v.hold});
    check({v.name, ".lu_ready"},  {31'd0, lu_ready},  {31'd0, v.ready});
    check({v.name, ".raw_stall"}, {31'd0, raw_stall}, {31'd0, v.stall});
    ewe = 1'b0; ea3 = '0; ewd = '0;
    if (v.hold || !(v.wb_we && v.wb_rd != 0)) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ewe = 1'b1; ea3 = e.rd; ewd = e.data;
      end
    end else begin
      ewe = 1'b1; ea3 = v.wb_rd; ewd = v.wb_data;
    end
    check({v.name, ".rf_we"}, {31'd0, rf_we}, {31'd0, ewe});
    if (ewe) begin
      check({v.name, ".rf_a3"}, {27'd0, rf_a3}, {27'd0, ea3});
      check({v.name, ".rf_wd"}, rf_wd, ewd);
    end
    e1 = (BYP && ewe && ea3 == v.rs1 && v.rs1 != 0) ? ewd : RD1_IN;
    e2 = (BYP && ewe && ea3 == v.rs2 && v.rs2 != 0) ? ewd : RD2_IN;
    check({v.name, ".rd1_out"}, rd1_out, e1);
    check({v.name, ".rd2_out"}, rd2_out, e2);
    $display("[%0t] %s: rf_we=%b a3=%0d wd=%h hold=%b ready=%b stall=%b",
             $time, v.name, rf_we, rf_a3, rf_wd, wb_hold, lu_ready, raw_stall);
    if (v.luv && v.ready && v.lu_rd != 0) begin
      ne.rd = v.lu_rd; ne.data = v.lu_data;
      exp_q.push_back(ne);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".rf_we"},     {31'd0, rf_we},     32'd0);
    check({nm, ".rf_a3"},     {27'd0, rf_a3},     32'd0);
    check({nm, ".rf_wd"},     rf_wd,              32'd0);
    check({nm, ".wb_hold"},   {31'd0, wb_hold},   32'd0);
    check({nm, ".lu_ready"},  {31'd0, lu_ready},  32'd0);
    check({nm, ".raw_stall"}, {31'd0, raw_stall}, 32'd0);
    check({nm, ".rd1_out"},   rd1_out,            32'd0);
    check({nm, ".rd2_out"},   rd2_out,            32'd0);
    $display("[%0t] %s: outputs under reset checked", $time, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: name, wb_we, wb_rd, wb_data, issue, issue_rd, lu_valid, lu_rd, lu_data, rs1, rs2, rd, hold, ready, stall
    tbl.push_back(mk("wb5",       1, 5, 32'hA5A5_0001, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("wb_x0",     1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("wb_fwd",    1, 3, 32'h3333_1234, 0, 0, 0, 0, 0,             3, 0, 0, 0, 1, !BYP));
    tbl.push_back(mk("lu_x0",     0, 0, 0,             1, 0, 1, 0, 32'hBAD0_BAD0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("x0_idle",   0, 0, 0,             0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("lu13",      0, 0, 0,             0, 0, 1, 13, 32'h1313_0013, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("wbx0_fifo", 1, 0, 32'h0000_0077, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("iss9",      0, 0, 0,             1, 9, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("rs2_9",     0, 0, 0,             0, 0, 0, 0, 0,             0, 9, 0, 0, 1, 1));
    tbl.push_back(mk("lu9",       0, 0, 0,             0, 0, 1, 9, 32'h9999_0009, 9, 0, 0, 0, 1, 1));
    tbl.push_back(mk("cmt9",      0, 0, 0,             0, 0, 0, 0, 0,             9, 0, 0, 0, 1, !BYP));
    tbl.push_back(mk("post9",     0, 0, 0,             0, 0, 0, 0, 0,             9, 0, 0, 0, 1, 0));
    tbl.push_back(mk("iss4",      0, 0, 0,             1, 4, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("lu4a",      0, 0, 0,             0, 0, 1, 4, 32'h4444_000A, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("iss4_cmt",  0, 0, 0,             1, 4, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("waw_rd4",   0, 0, 0,             0, 0, 0, 0, 0,             0, 0, 4, 0, 1, 1));
    tbl.push_back(mk("lu4b",      0, 0, 0,             0, 0, 1, 4, 32'h4444_000B, 4, 0, 0, 0, 1, 1));
    tbl.push_back(mk("cmt4b",     0, 0, 0,             0, 0, 0, 0, 0,             4, 0, 0, 0, 1, !BYP));
    tbl.push_back(mk("post4",     0, 0, 0,             0, 0, 0, 0, 0,             4, 0, 0, 0, 1, 0));
    tbl.push_back(mk("lu7",       0, 0, 0,             0, 0, 1, 7, 32'h7777_0007, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("wb3_win%0d", i), 1, 3, 32'h3333_0003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("starve",    1, 3, 32'h3333_0003, 0, 0, 0, 0, 0,             0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("wb3_after", 1, 3, 32'h3333_0003, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("bp1",       1, 3, 32'h3000_0001, 0, 0, 1, 10, 32'hE0E0_0001, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("bp2",       1, 3, 32'h3000_0002, 0, 0, 1, 11, 32'hE0E0_0002, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("bp3",       1, 3, 32'h3000_0003, 0, 0, 1, 12, 32'hE0E0_0003, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("bp4",       1, 3, 32'h3000_0004, 0, 0, 1, 12, 32'hE0E0_0003, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("bp5",       0, 0, 0,             0, 0, 1, 12, 32'hE0E0_0003, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("bp6",       0, 0, 0,             0, 0, 1, 12, 32'hE0E0_0003, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("bp7",       0, 0, 0,             0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("bp8",       0, 0, 0,             0, 0, 0, 0, 0,             0, 0, 0, 0, 1, 0));

    rst_n = 1'b0;
    wb_we = 0; wb_rd = 0; wb_data = 0; lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    rd1_in = RD1_IN; rd2_in = RD2_IN;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_cycle(tbl[i]);

    // Mid-operation reset with a queued result and a busy register.
    run_cycle(mk("pre_rst1", 1, 3, 32'h3000_0010, 1, 9, 1, 20, 32'h2020_0020, 0, 0, 0, 0, 1, 0));
    run_cycle(mk("pre_rst2", 1, 3, 32'h3000_0011, 0, 0, 0, 0, 0,             9, 0, 0, 0, 1, 1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(mk("post_rst1", 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0));
    run_cycle(mk("post_rst2", 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 0, 1, 0));

    check("drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
